// File: rtl/instr_mem_loader_if.sv
// Byte-stream load port and instruction-memory write port of the loader.
// The slave view belongs to the loader and the master view to the host or bench.
interface instr_mem_loader_if #(
  parameter int ADDR_W = 10
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   word_count;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, base_addr, word_count, byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata, busy, done, err
  );

  modport slave (
    input  start, base_addr, word_count, byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata, busy, done, err
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Packs a byte stream into 16-bit instruction words, writes them to consecutive
// addresses and checks a trailing XOR checksum, holding busy during the load.
module instr_mem_loader #(
  parameter int ADDR_W = 10,
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  instr_mem_loader_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    W_HI  = 3'd1,
    W_LO  = 3'd2,
    WRITE = 3'd3,
    C_HI  = 3'd4,
    C_LO  = 3'd5,
    FIN   = 3'd6
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W:0]     r_cnt;
  logic [WORD_W-1:0]   r_wdata;
  logic [WORD_W-1:0]   r_acc;
  logic [WORD_W-1:0]   r_chk;
  logic                r_err;
  logic                w_ready;
  logic                w_we;
  logic                w_busy;
  logic                w_done;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-state output decode
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_we        = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = (bus.word_count != '0) ? W_HI : C_HI;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      W_HI: begin
        w_ready = 1'b1;
        w_busy  = 1'b1;
        w_state_nxt = bus.byte_valid ? W_LO : W_HI;
      end
      W_LO: begin
        w_ready = 1'b1;
        w_busy  = 1'b1;
        w_state_nxt = bus.byte_valid ? WRITE : W_LO;
      end
      WRITE: begin
        w_we   = 1'b1;
        w_busy = 1'b1;
        w_state_nxt = (r_cnt == (ADDR_W+1)'(1)) ? C_HI : W_HI;
      end
      C_HI: begin
        w_ready = 1'b1;
        w_busy  = 1'b1;
        w_state_nxt = bus.byte_valid ? C_LO : C_HI;
      end
      C_LO: begin
        w_ready = 1'b1;
        w_busy  = 1'b1;
        w_state_nxt = bus.byte_valid ? FIN : C_LO;
      end
      FIN: begin
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: address/count latching, byte packing, checksum accumulate and compare
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_addr  <= '0;
      r_cnt   <= '0;
      r_wdata <= '0;
      r_acc   <= '0;
      r_chk   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_addr <= bus.base_addr;
            r_cnt  <= bus.word_count;
            r_acc  <= '0;
            r_err  <= 1'b0;
          end
        end
        W_HI: if (bus.byte_valid) r_wdata[15:8] <= bus.byte_in;
        W_LO: if (bus.byte_valid) r_wdata[7:0]  <= bus.byte_in;
        WRITE: begin
          r_acc  <= r_acc ^ r_wdata;
          r_addr <= r_addr + ADDR_W'(1);
          r_cnt  <= r_cnt - (ADDR_W+1)'(1);
        end
        C_HI: if (bus.byte_valid) r_chk[15:8] <= bus.byte_in;
        C_LO: begin
          if (bus.byte_valid) begin
            r_chk[7:0] <= bus.byte_in;
            r_err      <= ({r_chk[15:8], bus.byte_in} != r_acc);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Gating with rst keeps a reset landing on WRITE from producing a strobe
  assign bus.byte_ready = w_ready & rst;
  assign bus.mem_we     = w_we & rst;
  assign bus.busy       = w_busy & rst;
  assign bus.done       = w_done & rst;
  assign bus.mem_addr   = r_addr;
  assign bus.mem_wdata  = r_wdata;
  assign bus.err        = r_err;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized and directed load sequences checked against a word-level model
// of the expected writes, final address, done pulse and checksum error flag.
module tb_instr_mem_loader;
  localparam int ADDR_W = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   done_cnt = 0;
  logic [25:0] cap[$];
  logic [25:0] exp_w[$];
  logic [7:0]  stream[$];

  instr_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  instr_mem_loader #(.ADDR_W(ADDR_W), .WORD_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) cap.push_back({bus.mem_addr, bus.mem_wdata});
    if (bus.done === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    bus.byte_valid = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
    bus.byte_valid = 1'b1;
    bus.byte_in    = b;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.byte_ready !== 1'b1 && n < 100);
    if (n >= 100) chk("ready_timeout", 32'(bus.byte_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'($urandom);
  endtask

  // Runs one load of the bytes in stream and checks it against the model
  task automatic run_load(input logic [9:0] base, input logic [10:0] cnt,
                          input int gap_max, input bit rnd_gap, input bit poke);
    logic [15:0] acc;
    logic [15:0] rx;
    logic [9:0]  a;
    int n;
    cap.delete();
    exp_w.delete();
    done_cnt = 0;
    acc = 16'h0000;
    for (int i = 0; i < int'(cnt); i++) begin
      a = base + 10'(i);
      exp_w.push_back({a, stream[2*i], stream[2*i+1]});
      acc = acc ^ {stream[2*i], stream[2*i+1]};
    end
    rx = {stream[2*cnt], stream[2*cnt+1]};

    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.base_addr = base;
    bus.word_count = cnt;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.base_addr = 10'($urandom);
    bus.word_count = 11'($urandom);
    for (int j = 0; j < stream.size(); j++) begin
      if (poke && j == 1) begin
        bus.start = 1'b1;
        bus.base_addr = 10'h2AA;
        bus.word_count = 11'd5;
      end
      send_byte(stream[j], rnd_gap ? int'($urandom_range(0, gap_max)) : gap_max);
      bus.start = 1'b0;
    end

    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.done !== 1'b1 && n < 20);
    chk("done_seen", 32'(bus.done), 32'd1);
    chk("busy_at_done", 32'(bus.busy), 32'd0);
    chk("err", 32'(bus.err), 32'(rx != acc));
    bus.start = 1'b1;
    bus.base_addr = 10'h123;
    bus.word_count = 11'd1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("start_in_fin_ignored", 32'(bus.busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("err_sticky", 32'(bus.err), 32'(rx != acc));
    chk("final_addr", 32'(bus.mem_addr), 32'(10'(base + 10'(cnt))));
    chk("write_count", 32'(cap.size()), 32'(cnt));
    for (int i = 0; i < exp_w.size() && i < cap.size(); i++) begin
      chk("write", 32'(cap[i]), 32'(exp_w[i]));
    end
  endtask

  task automatic push_words_random(input int cnt, input bit bad);
    logic [15:0] w;
    logic [15:0] acc;
    stream.delete();
    acc = 16'h0000;
    for (int i = 0; i < cnt; i++) begin
      w = 16'($urandom);
      acc = acc ^ w;
      stream.push_back(w[15:8]);
      stream.push_back(w[7:0]);
    end
    if (bad) acc = acc ^ 16'(1 << $urandom_range(0, 15));
    stream.push_back(acc[15:8]);
    stream.push_back(acc[7:0]);
  endtask

  initial begin
    logic [10:0] c;
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.word_count = '0;
    bus.byte_in = 8'h00;
    bus.byte_valid = 1'b1;

    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ready", 32'(bus.byte_ready), 32'd0);
    chk("rst_we", 32'(bus.mem_we), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_addr", 32'(bus.mem_addr), 32'd0);
    #1 rst = 1'b1;
    bus.byte_valid = 1'b0;

    stream = '{8'h44, 8'hF0, 8'h45, 8'h60, 8'h01, 8'h90};
    run_load(10'h000, 11'd2, 0, 1'b0, 1'b0);
    stream = '{8'h44, 8'hF0, 8'h45, 8'h60, 8'h01, 8'h91};
    run_load(10'h000, 11'd2, 0, 1'b0, 1'b0);
    stream = '{8'h0C, 8'h10, 8'h12, 8'h40, 8'h1E, 8'h50};
    run_load(10'h3FF, 11'd2, 3, 1'b0, 1'b0);
    stream = '{8'h00, 8'h00};
    run_load(10'h155, 11'd0, 1, 1'b0, 1'b0);
    stream = '{8'h44, 8'hF0, 8'h45, 8'h60, 8'h01, 8'h90};
    run_load(10'h0A0, 11'd2, 1, 1'b0, 1'b1);

    // reset lands on the WRITE cycle of the first word
    cap.delete();
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.base_addr = 10'h010;
    bus.word_count = 11'd2;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_we", 32'(bus.mem_we), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_ready", 32'(bus.byte_ready), 32'd0);
    chk("midrst_nowrite", 32'(cap.size()), 32'd0);
    stream = '{8'h44, 8'hF0, 8'h45, 8'h60, 8'h01, 8'h90};
    run_load(10'h000, 11'd2, 0, 1'b0, 1'b0);

    for (int k = 0; k < 8; k++) begin
      c = (k == 3) ? 11'd0 : 11'($urandom_range(1, 6));
      push_words_random(int'(c), $urandom_range(0, 2) == 0);
      run_load(10'($urandom), c, 3, 1'b1, k == 5);
    end

    push_words_random(1024, 1'b0);
    run_load(10'h155, 11'd1024, 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
